// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS-subset control path.
//
// Contents:
//   state_t       - sequencer state encodings (S_*)
//   ALUOP_*       - 2-bit codes consumed by the ALU control decoder
//   OP_*          - instruction opcode constants (IR[31:26])
//   PCSRC_*       - pc_source mux select encodings
//   ALUB_*        - alu_src_b mux select encodings
//   ctrl_t        - packed control word produced by mc_ctrl_decode
//   dispatch_state()  - opcode to first execute-phase state
//   retires_on_exit() - states whose exit to S_FETCH completes an instruction
package cpu_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_LW    = 2'b00;
    localparam logic [1:0] ALUOP_SW    = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [5:0] OP_RTYPE     = 6'b000000;
    localparam logic [5:0] OP_LW        = 6'b100011;
    localparam logic [5:0] OP_SW        = 6'b101011;
    localparam logic [5:0] OP_BEQ       = 6'b000100;
    localparam logic [5:0] OP_J         = 6'b000010;
    localparam logic [2:0] OP_ITYPE_PFX = 3'b001;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    // First state after S_DECODE for a given opcode.
    function automatic state_t dispatch_state(input logic [5:0] op);
        state_t s;
        if ((op == OP_LW) || (op == OP_SW)) begin
            s = S_MEM_ADDR;
        end else if (op == OP_RTYPE) begin
            s = S_R_EXEC;
        end else if (op == OP_BEQ) begin
            s = S_BRANCH;
        end else if (op == OP_J) begin
            s = S_JUMP;
        end else if (op[5:3] == OP_ITYPE_PFX) begin
            s = S_I_EXEC;
        end else begin
            s = S_ILLEGAL;
        end
        return s;
    endfunction

    // S_ILLEGAL also returns to S_FETCH but does not retire anything.
    function automatic logic retires_on_exit(input state_t s);
        logic r;
        case (s)
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decode for the multi-cycle sequencer.
//
// Ports:
//   state     in  current sequencer state
//   mem_ready in  memory completes the current access this cycle
//   ctrl      out control word (mux selects, enables, alu_op)
//
// Everything is Moore-decoded from state, except ir_write/pc_write in
// S_FETCH which only fire in the cycle the instruction word arrives.
// Unused encodings fall through to an all-zero word.
module mc_ctrl_decode
    import cpu_defs::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_LW;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_IMM_SH2;
                ctrl.alu_op    = ALUOP_LW;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_SW;
            end
            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b0;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALUOP_BEQ;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control sequencer for the MIPS-subset datapath.
// Holds the state register, next-state logic and optional perf counters;
// the per-state control word comes from mc_ctrl_decode.
//
// Parameters:
//   STATE_W   - width of the state_o debug port
//   RST_STATE - state entered while rst_n is low
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   opcode[5:0]      IR[31:26], valid from S_DECODE onward
//   mem_ready        memory completes the current access this cycle
//   mem_req, mem_we, i_or_d               memory interface controls
//   ir_write, pc_write, pc_write_cond     register enables
//   pc_source[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0]   ALU/PC muxes
//   reg_dst, mem_to_reg, reg_write        register file controls
//   illegal_op       one-cycle pulse on an undefined opcode
//   state_o          current state (debug)
//
// Optional build macro MC_CTRL_PERF_EN adds:
//   instr_retired[31:0]  retired instruction count (illegal ops excluded)
//   stall_cycles[31:0]   cycles with mem_req=1 and mem_ready=0
module mc_ctrl_fsm
    import cpu_defs::*;
#(
    parameter state_t RST_STATE = S_FETCH,
    parameter int     STATE_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]        instr_retired,
    output logic [31:0]        stall_cycles
`endif
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RST_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_next = dispatch_state(opcode);
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_I_EXEC:   state_next = S_I_WB;
            S_R_EXEC:   state_next = S_R_WB;
            // Writeback, branch, jump, illegal and any stray encoding
            // all return to fetch.
            default:    state_next = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign illegal_op    = ctrl.illegal_op;
    assign state_o       = STATE_W'(state_reg);

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_retired_reg;
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired_reg <= '0;
            stall_cycles_reg  <= '0;
        end else begin
            // S_MEM_WR only leaves on mem_ready, hence the next-state test.
            if (retires_on_exit(state_reg) && (state_next == S_FETCH)) begin
                instr_retired_reg <= instr_retired_reg + 32'd1;
            end
            if (ctrl.mem_req && !mem_ready) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign instr_retired = instr_retired_reg;
    assign stall_cycles  = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
    import cpu_defs::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_retired, stall_cycles;
`endif

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
`ifdef MC_CTRL_PERF_EN
        ,
        .instr_retired (instr_retired),
        .stall_cycles  (stall_cycles)
`endif
    );

    // Expected per-instruction observation, spanning one S_FETCH entry to the next.
    typedef struct {
        logic [5:0] op;
        int cycles;
        int n_ir, n_pcw, n_cond, n_regw, m2r, dst;
        int n_dwr, n_drd, n_ill, n_alu_r, n_alu_i, n_beq, n_jmp;
    } exp_t;

    typedef struct {
        int         wait_cycles;
        bit         is_fetch;
        logic [5:0] op;
    } acc_t;

    exp_t sb[$];
    acc_t acc_q[$];

    int tests = 0;
    int fails = 0;
    int txn_idx = 0;
    int retired_exp = 0;
    int stall_seen = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: derived from the instruction class, not from states.
    function automatic exp_t model(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        int   opn;
        bit   lw, sw, rt, beq, j, it, ill;
        e = '{default: 0};
        opn = int'(op);
        lw  = (opn == 35);
        sw  = (opn == 43);
        rt  = (opn == 0);
        beq = (opn == 4);
        j   = (opn == 2);
        it  = (opn / 8 == 1);
        ill = !(lw || sw || rt || beq || j || it);
        e.op = op;
        if (lw)           e.cycles = 5 + fw + mw;
        else if (sw)      e.cycles = 4 + fw + mw;
        else if (rt || it) e.cycles = 4 + fw;
        else              e.cycles = 3 + fw;
        e.n_ir    = 1;
        e.n_pcw   = j ? 2 : 1;
        e.n_cond  = beq ? 1 : 0;
        e.n_regw  = (lw || rt || it) ? 1 : 0;
        e.m2r     = lw ? 1 : 0;
        e.dst     = rt ? 1 : 0;
        e.n_dwr   = sw ? mw + 1 : 0;
        e.n_drd   = lw ? mw + 1 : 0;
        e.n_ill   = ill ? 1 : 0;
        e.n_alu_r = rt ? 1 : 0;
        e.n_alu_i = it ? 1 : 0;
        e.n_beq   = beq ? 1 : 0;
        e.n_jmp   = j ? 1 : 0;
        return e;
    endfunction

    task automatic issue(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        acc_t a;
        e = model(op, fw, mw);
        sb.push_back(e);
        a.wait_cycles = fw; a.is_fetch = 1'b1; a.op = op;
        acc_q.push_back(a);
        if (e.n_dwr > 0 || e.n_drd > 0) begin
            a.wait_cycles = mw; a.is_fetch = 1'b0; a.op = op;
            acc_q.push_back(a);
        end
        if (e.n_ill == 0) retired_exp++;
    endtask

    task automatic issue_random();
        logic [5:0] op;
        int fw, mw;
        case ($urandom_range(0, 7))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = {3'b001, 3'($urandom_range(0, 7))};
            6: op = 6'($urandom_range(0, 63));
            default: op = 6'b100011;
        endcase
        fw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        mw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        issue(op, fw, mw);
    endtask

    // Memory responder: serves accesses in program order with planned wait states.
    acc_t cur;
    bit   busy = 1'b0;
    int   cur_wait = 0;
    initial begin
        mem_ready = 1'b0;
        opcode    = 6'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0; cur_wait = 0; mem_ready = 1'b0;
            end else begin
                if (!busy && mem_req && acc_q.size() > 0) begin
                    cur = acc_q.pop_front();
                    busy = 1'b1;
                    cur_wait = cur.wait_cycles;
                end
                if (busy) begin
                    if (cur_wait > 0) begin
                        mem_ready = 1'b0; cur_wait--; stall_seen++;
                    end else begin
                        mem_ready = 1'b1; busy = 1'b0;
                        if (cur.is_fetch) opcode = cur.op;
                    end
                end else begin
                    mem_ready = 1'b0;
                    if (mem_req) stall_seen++;
                end
            end
        end
    end

    // Monitor: accumulates observations per instruction and pops the scoreboard
    // each time the sequencer re-enters S_FETCH.
    bit   started = 1'b0;
    logic [3:0] prev_st;
    int span, n_ir, n_pcw, n_cond, n_regw, m2r, dst;
    int n_dwr, n_drd, n_ill, n_alu_r, n_alu_i, n_beq, n_jmp;

    task automatic clear_acc();
        span = 0; n_ir = 0; n_pcw = 0; n_cond = 0; n_regw = 0; m2r = 0; dst = 0;
        n_dwr = 0; n_drd = 0; n_ill = 0; n_alu_r = 0; n_alu_i = 0; n_beq = 0; n_jmp = 0;
    endtask

    task automatic close_span();
        exp_t  e;
        string p;
        txn_idx++;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL txn%0d unexpected: got an instruction, expected none", txn_idx);
        end else begin
            e = sb.pop_front();
            p = $sformatf("txn%0d op=%b", txn_idx, e.op);
            $display("[TB] txn %0d op=%b cycles=%0d exp=%0d regw=%0d ill=%0d",
                     txn_idx, e.op, span, e.cycles, n_regw, n_ill);
            check({p, " cycles"},   span,    e.cycles);
            check({p, " ir_write"}, n_ir,    e.n_ir);
            check({p, " pc_write"}, n_pcw,   e.n_pcw);
            check({p, " pc_cond"},  n_cond,  e.n_cond);
            check({p, " reg_write"}, n_regw, e.n_regw);
            check({p, " mem_to_reg"}, m2r,   e.m2r);
            check({p, " reg_dst"},  dst,     e.dst);
            check({p, " data_wr"},  n_dwr,   e.n_dwr);
            check({p, " data_rd"},  n_drd,   e.n_drd);
            check({p, " illegal"},  n_ill,   e.n_ill);
            check({p, " aluop_r"},  n_alu_r, e.n_alu_r);
            check({p, " aluop_i"},  n_alu_i, e.n_alu_i);
            check({p, " beq"},      n_beq,   e.n_beq);
            check({p, " jump"},     n_jmp,   e.n_jmp);
        end
    endtask

    initial begin
        clear_acc();
        prev_st = 4'd0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                started = 1'b0;
            end else begin
                if (!started) begin
                    started = 1'b1;
                    clear_acc();
                    prev_st = 4'(S_FETCH);
                end
                if (state_o == 4'(S_FETCH) && prev_st != 4'(S_FETCH) && span > 0) begin
                    close_span();
                    clear_acc();
                end
                n_ir    += int'(ir_write);
                n_pcw   += int'(pc_write);
                n_cond  += int'(pc_write_cond);
                if (reg_write) begin
                    n_regw++;
                    if (mem_to_reg) m2r = 1;
                    if (reg_dst) dst = 1;
                end
                if (mem_req && mem_we && i_or_d) n_dwr++;
                if (mem_req && !mem_we && i_or_d) n_drd++;
                n_ill   += int'(illegal_op);
                if (alu_op == 2'b10) n_alu_r++;
                if (alu_op == 2'b11 && alu_src_b == 2'b10) n_alu_i++;
                if (pc_write_cond && pc_source == 2'b01 && alu_op == 2'b01) n_beq++;
                if (pc_write && pc_source == 2'b10 && !ir_write) n_jmp++;
                span++;
                prev_st = state_o;
            end
        end
    end

    task automatic drain(input string tag);
        int  k;
        bit  done;
        done = 1'b0;
        for (k = 0; k < 4000 && !done; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && acc_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s drain timeout: got %0d pending, expected 0", tag, sb.size());
        end
`ifdef MC_CTRL_PERF_EN
        check({tag, " instr_retired"}, int'(instr_retired), retired_exp);
        check({tag, " stall_cycles"},  int'(stall_cycles),  stall_seen);
`endif
    endtask

    initial begin
        int  k;
        bit  found;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst state_o",   int'(state_o),   int'(S_FETCH));
        check("rst mem_req",   int'(mem_req),   1);
        check("rst mem_we",    int'(mem_we),    0);
        check("rst alu_src_a", int'(alu_src_a), 0);
        check("rst alu_src_b", int'(alu_src_b), 1);
        check("rst alu_op",    int'(alu_op),    0);
        check("rst pc_source", int'(pc_source), 0);
        check("rst pc_write",  int'(pc_write),  0);
        check("rst ir_write",  int'(ir_write),  0);
        check("rst reg_write", int'(reg_write), 0);
        check("rst illegal",   int'(illegal_op), 0);

        // Directed prefix, then randomized stream.
        issue(6'b000000, 0, 0);
        issue(6'b100011, 2, 3);
        issue(6'b101011, 0, 0);
        issue(6'b000100, 0, 0);
        issue(6'b000010, 0, 0);
        issue(6'b001100, 0, 0);
        issue(6'b111111, 0, 0);
        for (int i = 0; i < 40; i++) issue_random();

        @(posedge clk);
        #1 rst_n = 1'b1;
        drain("phase1");

        // Abandon a store mid-wait with an asynchronous reset.
        issue(6'b101011, 0, 8);
        found = 1'b0;
        for (k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #2;
            if (state_o == 4'(S_MEM_WR)) found = 1'b1;
        end
        check("reach S_MEM_WR", int'(found), 1);
        @(negedge clk);
        check("pre-reset mem_req", int'(mem_req), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async rst state_o", int'(state_o), int'(S_FETCH));
        check("async rst mem_we",  int'(mem_we),  0);
        while (sb.size() > 0) void'(sb.pop_back());
        acc_q.delete();
        repeat (2) @(posedge clk);
        retired_exp = 0;
        stall_seen  = 0;
        issue(6'b100011, 1, 0);
        for (int i = 0; i < 10; i++) issue_random();
        #1 rst_n = 1'b1;
        drain("phase2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
